cpu_phase_sequencer: RTL and testbench

//  Consumes the free-running clk and the go level from the clock generator and

---
 rtl/cpu_phase_if.sv | 29 ++
 rtl/cpu_phase_sequencer.sv | 117 +++++++++++
 tb/tb_cpu_phase_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_phase_if.sv
// Control/status bundle between the clock generator, control unit and the
// multicycle phase sequencer.
interface cpu_phase_if #(
  parameter int CW = 32,
  parameter int IW = 32
);
  logic          go;
  logic          step;
  logic          halt_req;
  logic          halt_clr;
  logic [1:0]    inst_class;
  logic [4:0]    phase;
  logic          cpu_en;
  logic          instr_done;
  logic          running;
  logic          halted;
  logic [CW-1:0] cycle_count;
  logic [IW-1:0] instr_count;

  modport master (
    output go, step, halt_req, halt_clr, inst_class,
    input  phase, cpu_en, instr_done, running, halted, cycle_count, instr_count
  );

  modport slave (
    input  go, step, halt_req, halt_clr, inst_class,
    output phase, cpu_en, instr_done, running, halted, cycle_count, instr_count
  );
endinterface

// File: rtl/cpu_phase_sequencer.sv
// Multicycle MIPS phase sequencer: run/step/halt modes, one-hot IF..WB phase,
// commit enable and wrapping cycle/instruction counters.
//
// state  | meaning
// IDLE   | stopped at an instruction boundary, phase parked at IF
// RUN    | free-running, re-checks go at every instruction end
// STEP   | executing exactly one instruction, then back to IDLE
// HALTED | stopped by break/syscall until halt_clr
module cpu_phase_sequencer #(
  parameter int CW = 32,
  parameter int IW = 32
) (
  input  logic        clk,
  input  logic        reset,
  cpu_phase_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [4:0] PH_IF  = 5'b00001;
  localparam logic [4:0] PH_ID  = 5'b00010;
  localparam logic [4:0] PH_EX  = 5'b00100;
  localparam logic [4:0] PH_MEM = 5'b01000;
  localparam logic [4:0] PH_WB  = 5'b10000;

  localparam logic [1:0] C_BR    = 2'd0;
  localparam logic [1:0] C_ALU   = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  logic [1:0]    state, state_nx;
  logic [4:0]    phase_q, phase_nx;
  logic [1:0]    class_q;
  logic          halt_pend;
  logic          last_phase;
  logic          active;
  logic          done;
  logic [CW-1:0] cycle_q;
  logic [IW-1:0] instr_q;

  assign active = (state == S_RUN) || (state == S_STEP);
  assign done   = active && last_phase;

  // class_q only matters from EX onward; IF and ID are never the last phase
  always_comb begin
    last_phase = 1'b0;
    phase_nx   = PH_IF;
    case (phase_q)
      PH_IF: phase_nx = PH_ID;
      PH_ID: phase_nx = PH_EX;
      PH_EX: begin
        if (class_q == C_BR)       last_phase = 1'b1;
        else if (class_q == C_ALU) phase_nx   = PH_WB;
        else                       phase_nx   = PH_MEM;
      end
      PH_MEM: begin
        if (class_q == C_STORE) last_phase = 1'b1;
        else                    phase_nx   = PH_WB;
      end
      PH_WB:   last_phase = 1'b1;
      default: phase_nx   = PH_IF;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.go)        state_nx = S_RUN;
        else if (bus.step) state_nx = S_STEP;
      end
      S_RUN, S_STEP: begin
        if (done) begin
          if (halt_pend || bus.halt_req) state_nx = S_HALTED;
          else if (state == S_STEP)      state_nx = S_IDLE;
          else if (!bus.go)              state_nx = S_IDLE;
        end
      end
      S_HALTED: begin
        if (bus.halt_clr) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_q   <= PH_IF;
      class_q   <= 2'd3;
      halt_pend <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      state <= state_nx;
      if (active) phase_q <= phase_nx;
      else        phase_q <= PH_IF;
      if (active && phase_q == PH_ID) class_q <= bus.inst_class;
      // a pending halt always wins at the boundary, so clearing on any done is safe
      if (done)                                    halt_pend <= 1'b0;
      else if (bus.halt_req && state != S_HALTED) halt_pend <= 1'b1;
      if (active) cycle_q <= cycle_q + CW'(1);
      if (done)   instr_q <= instr_q + IW'(1);
    end
  end

  assign bus.phase       = phase_q;
  assign bus.cpu_en      = active;
  assign bus.running     = active;
  assign bus.instr_done  = done;
  assign bus.halted      = (state == S_HALTED);
  assign bus.cycle_count = cycle_q;
  assign bus.instr_count = instr_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Bench for cpu_phase_sequencer: one stimulus drives a 32-bit-counter and a
// 4-bit-counter instance, both checked every cycle against a phase-list model.
module tb_cpu_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0, step = 1'b0, halt_req = 1'b0, halt_clr = 1'b0;
  logic [1:0] inst_class = 2'd0;

  always #5 clk = ~clk;

  cpu_phase_if #(.CW(32), .IW(32)) bus ();
  cpu_phase_if #(.CW(4),  .IW(4))  bus4 ();

  assign bus.go = go;        assign bus4.go = go;
  assign bus.step = step;    assign bus4.step = step;
  assign bus.halt_req = halt_req; assign bus4.halt_req = halt_req;
  assign bus.halt_clr = halt_clr; assign bus4.halt_clr = halt_clr;
  assign bus.inst_class = inst_class; assign bus4.inst_class = inst_class;

  cpu_phase_sequencer #(.CW(32), .IW(32)) dut   (.clk(clk), .reset(reset), .bus(bus));
  cpu_phase_sequencer #(.CW(4),  .IW(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: mode plus position within the instruction's phase list.
  localparam int MI = 0, MR = 1, MS = 2, MH = 3;
  int          m_mode = MI, m_pos = 0, m_cls = 3;
  bit          m_pend = 1'b0;
  int unsigned m_cyc = 0, m_ins = 0;

  function automatic int seq_len(input int cls);
    case (cls)
      0: return 3;
      1: return 4;
      2: return 4;
      default: return 5;
    endcase
  endfunction

  // phase index 0..4 = IF,ID,EX,MEM,WB for position pos of the list
  function automatic int seq_idx(input int cls, input int pos);
    if (pos <= 2) return pos;
    if (pos == 3) return (cls == 1) ? 4 : 3;
    return 4;
  endfunction

  always @(posedge clk) begin : model
    bit fin;
    if (reset) begin
      m_mode = MI; m_pos = 0; m_cls = 3; m_pend = 1'b0; m_cyc = 0; m_ins = 0;
    end else begin
      case (m_mode)
        MI: begin
          if (halt_req) m_pend = 1'b1;
          if (go)        m_mode = MR;
          else if (step) m_mode = MS;
        end
        MR, MS: begin
          m_cyc++;
          fin = (m_pos == seq_len(m_cls) - 1);
          if (m_pos == 1) m_cls = int'(inst_class);
          if (fin) begin
            m_ins++;
            m_pos = 0;
            if (m_pend || halt_req) begin m_mode = MH; m_pend = 1'b0; end
            else if (m_mode == MS) m_mode = MI;
            else if (!go)          m_mode = MI;
          end else begin
            m_pos++;
            if (halt_req) m_pend = 1'b1;
          end
        end
        default: if (halt_clr) m_mode = MI;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    bit          e_run;
    logic [31:0] e_ph;
    if (chk_en) begin
      e_run = (m_mode == MR) || (m_mode == MS);
      e_ph  = e_run ? (32'd1 << seq_idx(m_cls, m_pos)) : 32'd1;
      chk("phase",        {27'd0, bus.phase},       e_ph);
      chk("cpu_en",       {31'd0, bus.cpu_en},      {31'd0, e_run});
      chk("running",      {31'd0, bus.running},     {31'd0, e_run});
      chk("instr_done",   {31'd0, bus.instr_done},
          {31'd0, e_run && (m_pos == seq_len(m_cls) - 1)});
      chk("halted",       {31'd0, bus.halted},      {31'd0, m_mode == MH});
      chk("cycle_count",  bus.cycle_count,          m_cyc);
      chk("instr_count",  bus.instr_count,          m_ins);
      chk("phase4",       {27'd0, bus4.phase},      e_ph);
      chk("cycle_count4", {28'd0, bus4.cycle_count}, m_cyc & 32'hF);
      chk("instr_count4", {28'd0, bus4.instr_count}, m_ins & 32'hF);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    go = 1'b0; step = 1'b0; halt_req = 1'b0; halt_clr = 1'b0; inst_class = 2'd0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    tick(1);
    chk_en = 1'b1;
    do_reset();
    chk("rst_phase",  {27'd0, bus.phase}, 32'h01);
    chk("rst_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
    chk("rst_cycles", bus.cycle_count, 32'd0);

    // free-run LOADs, drop go inside the third instruction
    go = 1'b1; inst_class = 2'd3;
    tick(11);
    go = 1'b0;
    tick(6);
    chk("load_instrs", bus.instr_count, 32'd3);
    chk("load_cycles", bus.cycle_count, 32'd15);
    chk("load_idle",   {31'd0, bus.running}, 32'd0);

    // BR, ALU, STORE, LOAD back to back
    do_reset();
    go = 1'b1; inst_class = 2'd0;
    tick(3);  inst_class = 2'd1;
    tick(3);  inst_class = 2'd2;
    tick(4);  inst_class = 2'd3;
    tick(4);  go = 1'b0;
    tick(5);
    chk("mix_instrs",  bus.instr_count, 32'd4);
    chk("mix_cycles",  bus.cycle_count, 32'd16);
    chk("mix_cycles4", {28'd0, bus4.cycle_count}, 32'd0);

    // single step of an ALU instruction
    do_reset();
    step = 1'b1; inst_class = 2'd1;
    tick(1); step = 1'b0;
    tick(6);
    chk("step_instrs", bus.instr_count, 32'd1);
    chk("step_cycles", bus.cycle_count, 32'd4);
    chk("step_idle",   {31'd0, bus.running}, 32'd0);

    // halt_req in EX of a LOAD, then go/step ignored, halt_clr releases
    do_reset();
    go = 1'b1; inst_class = 2'd3;
    tick(3); halt_req = 1'b1;
    tick(1); halt_req = 1'b0;
    tick(3);
    chk("halt_on",    {31'd0, bus.halted}, 32'd1);
    chk("halt_instr", bus.instr_count, 32'd1);
    step = 1'b1; tick(2); step = 1'b0;
    chk("halt_stays", {31'd0, bus.halted}, 32'd1);
    chk("halt_noen",  {31'd0, bus.cpu_en}, 32'd0);
    go = 1'b0; halt_clr = 1'b1;
    tick(1); halt_clr = 1'b0;
    tick(2);
    chk("halt_clr",   {31'd0, bus.halted}, 32'd0);
    chk("halt_idle",  {31'd0, bus.running}, 32'd0);

    // go drops in ID of a STORE, then go+step together selects RUN
    do_reset();
    go = 1'b1; inst_class = 2'd2;
    tick(2); go = 1'b0;
    tick(4);
    chk("drop_instrs", bus.instr_count, 32'd1);
    chk("drop_cycles", bus.cycle_count, 32'd4);
    go = 1'b1; step = 1'b1; inst_class = 2'd0;
    tick(1); step = 1'b0;
    tick(5);
    chk("gostep_run", {31'd0, bus.running}, 32'd1);
    go = 1'b0;
    tick(6);

    // halt_req while idle is remembered until the next instruction ends
    do_reset();
    halt_req = 1'b1; tick(1); halt_req = 1'b0;
    halt_clr = 1'b1; tick(1); halt_clr = 1'b0;
    tick(1);
    go = 1'b1; inst_class = 2'd0;
    tick(1); go = 1'b0;
    tick(5);
    chk("pend_halt",  {31'd0, bus.halted}, 32'd1);
    halt_clr = 1'b1; tick(1); halt_clr = 1'b0;

    // 4-bit counter wrap after 17 enable cycles, then reset mid-EX
    do_reset();
    go = 1'b1; inst_class = 2'd3;
    tick(18);
    chk("wrap_cycles",  bus.cycle_count, 32'd17);
    chk("wrap_cycles4", {28'd0, bus4.cycle_count}, 32'd1);
    do_reset();
    go = 1'b1; inst_class = 2'd3;
    tick(3);
    reset = 1'b1; go = 1'b0;
    tick(1);
    reset = 1'b0;
    chk("midrst_phase",  {27'd0, bus.phase}, 32'h01);
    chk("midrst_done",   {31'd0, bus.instr_done}, 32'd0);
    chk("midrst_instrs", bus.instr_count, 32'd0);
    chk("midrst_cycles", bus.cycle_count, 32'd0);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
